// File: rtl/pipe_pkg.sv
// Shared types for the pipe_datapath slice.
//   alu_op_e      : ALU operation codes driven on alu_ctrl
//   result_src_e  : writeback source select
//   mem_ctrl_t    : control payload held in the MEM stage register
//   wb_ctrl_t     : control payload held in the WB stage register
package pipe_pkg;

    localparam int unsigned ALU_OP_W     = 4;
    localparam int unsigned RESULT_SRC_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    // Code 11 is a second encoding of the ALU result.
    typedef enum logic [RESULT_SRC_W-1:0] {
        RS_ALU     = 2'b00,
        RS_LOAD    = 2'b01,
        RS_PC4     = 2'b10,
        RS_ALU_ALT = 2'b11
    } result_src_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        result_src_e result_src;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
    } wb_ctrl_t;

    function automatic logic is_load(input result_src_e src);
        return src == RS_LOAD;
    endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU for the EX stage.
//   a, b : source operands (SrcA, SrcB)
//   op   : operation code (alu_op_e encoding); unknown codes give 0
//   y    : result, modulo 2**DATA_WIDTH
module pipe_alu
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ALU_OP_W-1:0]   op,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_signed;
    logic               lt_unsigned;

    assign shamt       = b[SHAMT_W-1:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    // Operation select.
    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU: y = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/pipe_datapath.sv
// Three-stage integer datapath: EX (operand read, forwarding, ALU),
// MEM (memory handshake), WB (register write).
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : issue-slot handshake
//   rs1, rs2, rd, imm_ext,
//   pc_plus4, alu_src,
//   alu_ctrl, mem_write,
//   reg_write, result_src    : decoded operation in the issue slot
//   mem_req/we/addr/wdata    : memory request, held until mem_ready
//   mem_rdata, mem_ready     : memory response
//   zero, alu_result         : registered ALU status of last accepted op
//   test_addr / test_data    : debug register read port
module pipe_datapath
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ADDR_W-1:0]   rs1,
    input  logic [REG_ADDR_W-1:0]   rs2,
    input  logic [REG_ADDR_W-1:0]   rd,
    input  logic [DATA_WIDTH-1:0]   imm_ext,
    input  logic [DATA_WIDTH-1:0]   pc_plus4,
    input  logic                    alu_src,
    input  logic [ALU_OP_W-1:0]     alu_ctrl,
    input  logic                    mem_write,
    input  logic                    reg_write,
    input  logic [RESULT_SRC_W-1:0] result_src,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    zero,
    output logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [REG_ADDR_W-1:0]   test_addr,
    output logic [DATA_WIDTH-1:0]   test_data
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    mem_ctrl_t             mem_ctrl;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] mem_alu;
    logic [DATA_WIDTH-1:0] mem_store_data;
    logic [DATA_WIDTH-1:0] mem_pc4;

    wb_ctrl_t              wb_ctrl;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  wb_we;
    logic [DATA_WIDTH-1:0] rs1_rf;
    logic [DATA_WIDTH-1:0] rs2_rf;
    logic                  mem_fwd_en;
    logic [DATA_WIDTH-1:0] mem_fwd_val;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] alu_y;
    logic                  rs2_used;
    logic                  mem_is_load;
    logic                  mem_busy;
    logic                  mem_hold;
    logic                  load_use;
    logic                  accept;
    logic [DATA_WIDTH-1:0] mem_result;

    // Register read with x0 hard-wired to zero and WB write-through.
    function automatic logic [DATA_WIDTH-1:0] rf_pick(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        if (addr == '0) begin
            return '0;
        end
        if (we && (waddr == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    assign wb_we     = wb_ctrl.valid & wb_ctrl.reg_write & (wb_rd != '0);
    assign rs1_rf    = rf_pick(rs1, regs[rs1], wb_we, wb_rd, wb_data);
    assign rs2_rf    = rf_pick(rs2, regs[rs2], wb_we, wb_rd, wb_data);
    assign test_data = rf_pick(test_addr, regs[test_addr], wb_we, wb_rd, wb_data);

    // A load in MEM has no data yet; it is handled by stalling, not forwarding.
    assign mem_is_load = mem_ctrl.valid & is_load(mem_ctrl.result_src);
    assign mem_fwd_en  = mem_ctrl.valid & mem_ctrl.reg_write & ~is_load(mem_ctrl.result_src);
    assign mem_fwd_val = (mem_ctrl.result_src == RS_PC4) ? mem_pc4 : mem_alu;

    // EX operand selection: x0, then MEM result, then WB/register file.
    always_comb begin
        src_a = rs1_rf;
        if (rs1 == '0) begin
            src_a = '0;
        end else if (mem_fwd_en && (mem_rd == rs1)) begin
            src_a = mem_fwd_val;
        end
    end

    always_comb begin
        rs2_fwd = rs2_rf;
        if (rs2 == '0) begin
            rs2_fwd = '0;
        end else if (mem_fwd_en && (mem_rd == rs2)) begin
            rs2_fwd = mem_fwd_val;
        end
    end

    assign src_b = alu_src ? imm_ext : rs2_fwd;

    pipe_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a  (src_a),
        .b  (src_b),
        .op (alu_ctrl),
        .y  (alu_y)
    );

    // ------------------------------------------------------------------
    // Hazards and handshake
    // ------------------------------------------------------------------
    assign rs2_used = ~alu_src | mem_write;
    assign mem_busy = mem_ctrl.valid & (mem_ctrl.mem_write | is_load(mem_ctrl.result_src));
    assign mem_hold = mem_busy & ~mem_ready;

    assign load_use = mem_is_load & (mem_rd != '0) &
                      ((mem_rd == rs1) | (rs2_used & (mem_rd == rs2)));

    // EX never issues behind a memory op, so the slot stays closed through
    // the mem_ready cycle as well; the bubble lets MEM drain into WB.
    assign in_ready = rst | ~(mem_busy | load_use);
    assign accept   = in_valid & in_ready;

    assign mem_req   = mem_busy & ~rst;
    assign mem_we    = mem_req & mem_ctrl.mem_write;
    assign mem_addr  = mem_alu;
    assign mem_wdata = mem_store_data;

    // Writeback value chosen at the MEM/WB boundary; load data is captured here.
    always_comb begin
        mem_result = mem_alu;
        case (mem_ctrl.result_src)
            RS_LOAD: mem_result = mem_rdata;
            RS_PC4:  mem_result = mem_pc4;
            default: mem_result = mem_alu;
        endcase
    end

    // ------------------------------------------------------------------
    // EX -> MEM register; holds while the memory request is outstanding.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ctrl       <= '0;
            mem_rd         <= '0;
            mem_alu        <= '0;
            mem_store_data <= '0;
            mem_pc4        <= '0;
        end else if (!mem_hold) begin
            if (accept) begin
                mem_ctrl <= '{valid:      1'b1,
                              reg_write:  reg_write,
                              mem_write:  mem_write,
                              result_src: result_src_e'(result_src)};
                mem_rd         <= rd;
                mem_alu        <= alu_y;
                mem_store_data <= rs2_fwd;
                mem_pc4        <= pc_plus4;
            end else begin
                mem_ctrl <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM -> WB register; a bubble enters while MEM waits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctrl <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (mem_ctrl.valid && !mem_hold) begin
            wb_ctrl <= '{valid: 1'b1, reg_write: mem_ctrl.reg_write};
            wb_rd   <= mem_rd;
            wb_data <= mem_result;
        end else begin
            wb_ctrl <= '0;
        end
    end

    // Register file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // ALU status of the most recently accepted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result <= '0;
            zero       <= 1'b0;
        end else if (accept) begin
            alu_result <= alu_y;
            zero       <= (alu_y == '0);
        end
    end

endmodule

// File: tb/tb_pipe_datapath.sv
module tb_pipe_datapath;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        zero;
    logic [31:0] alu_result;
    logic [4:0]  test_addr;
    logic [31:0] test_data;

    pipe_datapath #(
        .DATA_WIDTH (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .imm_ext    (imm_ext),
        .pc_plus4   (pc_plus4),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .alu_result (alu_result),
        .test_addr  (test_addr),
        .test_data  (test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic        alu_src;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  res_src;
        logic [31:0] exp_alu;
    } op_t;

    typedef struct packed {
        logic [31:0] alu;
        logic        z;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          mem_delay = 0;
    logic [31:0] load_val = 32'd0;
    logic [31:0] model [32];
    exp_t        exp_q [$];
    op_t         vec [21];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic op_t op_r(input logic [3:0] c, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [31:0] e);
        op_t o;
        o = '0;
        o.ctrl = c; o.rd = d; o.rs1 = s1; o.rs2 = s2;
        o.reg_write = 1'b1; o.exp_alu = e;
        return o;
    endfunction

    function automatic op_t op_i(input logic [3:0] c, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [31:0] im,
                                 input logic [31:0] e);
        op_t o;
        o = '0;
        o.ctrl = c; o.rd = d; o.rs1 = s1; o.imm = im; o.alu_src = 1'b1;
        o.reg_write = 1'b1; o.exp_alu = e;
        return o;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input op_t op, input string nm, output int stalls);
        exp_t e;
        rs1 = op.rs1; rs2 = op.rs2; rd = op.rd; imm_ext = op.imm;
        pc_plus4 = op.pc4; alu_src = op.alu_src; alu_ctrl = op.ctrl;
        mem_write = op.mem_write; reg_write = op.reg_write; result_src = op.res_src;
        in_valid = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (!in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready stuck at 0 for %0d cycles", nm, stalls);
        end
        exp_q.push_back('{alu: op.exp_alu, z: (op.exp_alu == 32'd0)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = exp_q.pop_front();
        check({nm, "_alu_result"}, alu_result, e.alu);
        check({nm, "_zero"}, 32'(zero), 32'(e.z));
        if (op.reg_write && op.rd != 5'd0)
            model[op.rd] = (op.res_src == 2'b10) ? op.pc4 :
                           (op.res_src == 2'b01) ? load_val : op.exp_alu;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            test_addr = 5'(i);
            @(negedge clk);
            check($sformatf("%s_x%0d", tag, i), test_data, model[i]);
        end
    endtask

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: mem_ready after mem_delay waiting cycles.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (wait_cnt >= mem_delay) begin
                    mem_ready = 1'b1;
                    wait_cnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   st;
        int   req_cycles;
        op_t  o;

        // Vector table: ALU ops back-to-back, exercising MEM and WB forwarding.
        vec[0]  = op_i(4'h0, 5'd1,  5'd0,  32'd5,        32'd5);         // ADDI x1=5
        vec[1]  = op_r(4'h0, 5'd2,  5'd1,  5'd1,         32'd10);        // ADD x2=x1+x1
        vec[2]  = op_i(4'h0, 5'd5,  5'd0,  32'd3,        32'd3);
        vec[3]  = op_i(4'h0, 5'd6,  5'd0,  32'd3,        32'd3);
        vec[4]  = op_r(4'h1, 5'd5,  5'd5,  5'd6,         32'd0);         // SUB 3-3
        vec[5]  = op_i(4'h0, 5'd8,  5'd0,  32'h80000000, 32'h80000000);
        vec[6]  = op_i(4'h9, 5'd9,  5'd8,  32'd4,        32'hF8000000);  // SRA
        vec[7]  = op_i(4'h0, 5'd10, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF);
        vec[8]  = op_i(4'h0, 5'd11, 5'd0,  32'd1,        32'd1);
        vec[9]  = op_r(4'h5, 5'd12, 5'd10, 5'd11,        32'd1);         // SLT -1<1
        vec[10] = op_r(4'h6, 5'd13, 5'd10, 5'd11,        32'd0);         // SLTU
        vec[11] = op_i(4'h8, 5'd14, 5'd8,  32'd4,        32'h08000000);  // SRL
        vec[12] = op_i(4'h7, 5'd15, 5'd11, 32'd31,       32'h80000000);  // SLL
        vec[13] = op_r(4'h2, 5'd16, 5'd10, 5'd9,         32'hF8000000);  // AND
        vec[14] = op_r(4'h3, 5'd17, 5'd11, 5'd2,         32'h0000000B);  // OR
        vec[15] = op_r(4'h4, 5'd18, 5'd10, 5'd1,         32'hFFFFFFFA);  // XOR
        vec[16] = op_r(4'hF, 5'd19, 5'd10, 5'd11,        32'd0);         // undefined op
        vec[17] = op_i(4'h0, 5'd0,  5'd0,  32'd7,        32'd7);         // write x0
        vec[18] = op_i(4'h0, 5'd1,  5'd0,  32'd0,        32'd0);         // link
        vec[18].res_src = 2'b10;
        vec[18].pc4     = 32'h104;
        vec[19] = op_r(4'h0, 5'd20, 5'd1,  5'd0,         32'h104);       // uses link via MEM
        vec[20] = op_r(4'h0, 5'd21, 5'd10, 5'd11,        32'd0);         // wraparound

        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        imm_ext = '0; pc_plus4 = '0; alu_src = 1'b0; alu_ctrl = '0;
        mem_write = 1'b0; reg_write = 1'b0; result_src = '0;
        mem_rdata = '0; test_addr = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready",   32'(in_ready), 32'd1);
        check("rst_mem_req",    32'(mem_req),  32'd0);
        check("rst_alu_result", alu_result,    32'd0);
        check("rst_zero",       32'(zero),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_mem_req",  32'(mem_req),  32'd0);

        sync_edge();
        for (int i = 0; i < 21; i++) begin
            issue(vec[i], $sformatf("vec%0d", i), st);
            check($sformatf("vec%0d_stalls", i), 32'(st), 32'd0);
        end

        // Store with a 3-cycle memory wait.
        o = op_i(4'h0, 5'd1, 5'd0, 32'h1234, 32'h1234);
        issue(o, "addi_store_data", st);
        o = op_i(4'h0, 5'd0, 5'd0, 32'h40, 32'h40);
        o.rs2 = 5'd1; o.mem_write = 1'b1; o.reg_write = 1'b0;
        mem_delay = 3;
        issue(o, "store", st);
        req_cycles = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                check($sformatf("store_addr_c%0d", c),     mem_addr,        32'h40);
                check($sformatf("store_wdata_c%0d", c),    mem_wdata,       32'h1234);
                check($sformatf("store_we_c%0d", c),       32'(mem_we),     32'd1);
                check($sformatf("store_in_ready_c%0d", c), 32'(in_ready),   32'd0);
            end
        end
        check("store_req_cycles", 32'(req_cycles), 32'd4);
        check("store_done_in_ready", 32'(in_ready), 32'd1);

        // Load followed by a dependent ADD: one stall cycle.
        mem_delay = 0;
        load_val  = 32'h1234;
        mem_rdata = 32'h1234;
        sync_edge();
        o = op_i(4'h0, 5'd3, 5'd0, 32'h40, 32'h40);
        o.res_src = 2'b01;
        issue(o, "load_x3", st);
        check("load_x3_stalls", 32'(st), 32'd0);
        o = op_r(4'h0, 5'd4, 5'd3, 5'd3, 32'h2468);
        issue(o, "load_use_add", st);
        check("load_use_stalls", 32'(st), 32'd1);
        repeat (3) @(negedge clk);
        sweep("regs");

        // Reset while a load is waiting, on the same edge as mem_ready.
        mem_delay = 2;
        load_val  = 32'h5555;
        mem_rdata = 32'h5555;
        sync_edge();
        o = op_i(4'h0, 5'd23, 5'd0, 32'h40, 32'h40);
        o.res_src = 2'b01;
        issue(o, "pending_load", st);
        @(negedge clk);
        check("pending_mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midreq_rst_mem_req",    32'(mem_req),  32'd0);
        check("midreq_rst_in_ready",   32'(in_ready), 32'd1);
        check("midreq_rst_alu_result", alu_result,    32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midreq_post_mem_req",  32'(mem_req),  32'd0);
        check("midreq_post_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        repeat (3) @(negedge clk);
        sweep("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the width of registers, ALU and memory data.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 5, meaning there are 2**REG_ADDR_W registers.
REQ-003 Clock and reset are decided: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue slot holds an operation.
- in_ready  out  1  block accepts the issue slot this cycle.
- rs1, rs2, rd  in  REG_ADDR_W each  register addresses.
- imm_ext  in  DATA_WIDTH  sign-extended immediate.
- pc_plus4  in  DATA_WIDTH  link value.
- alu_src  in  1  1 selects imm_ext as SrcB, 0 selects forwarded rs2.
- alu_ctrl  in  4  ALU operation code.
- mem_write  in  1  store operation.
- reg_write  in  1  operation writes rd.
- result_src  in  2  writeback source: 00 ALU, 01 load data, 10 pc_plus4, 11 ALU.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  DATA_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_ready  in  1  memory completes the request this cycle.
- zero  out  1  registered: ALU result of the last accepted operation was zero.
- alu_result  out  DATA_WIDTH  registered ALU result of the last accepted operation.
- test_addr  in  REG_ADDR_W  debug register read address.
- test_data  out  DATA_WIDTH  combinational read of register test_addr.

Function
REQ-005 The block SHALL be a 3-stage pipeline: EX (operand read, forwarding, ALU), MEM (memory access), WB (register write).
REQ-006 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-007 Register reads SHALL be combinational, with write-through: a WB write to the address being read in the same cycle returns the new value.
REQ-008 EX operand priority SHALL be: register 0 first, then the MEM-stage result (ALU result or pc_plus4), then the WB-stage result, then the register file.
- Forwarding applies only when that stage has reg_write=1 and the same rd.
REQ-009 Load-use: when MEM holds a load (result_src=01) whose rd≠0 matches a used rs1/rs2 of the issue slot, in_ready SHALL be 0 until the load completes.
- An operand counts as used as follows: rs1 always; rs2 if alu_src=0 or mem_write=1.
REQ-010 A memory operation in MEM SHALL assert mem_req continuously, with stable mem_we, mem_addr and mem_wdata, until the cycle mem_ready=1.
- mem_addr is the ALU result; mem_wdata is the forwarded rs2 latched at EX.
REQ-011 While a MEM request waits for mem_ready, MEM and EX SHALL hold and in_ready SHALL be 0; WB SHALL still retire its operation.
REQ-012 Non-memory operations SHALL pass through MEM in one cycle with mem_req=0.
REQ-013 An accepted operation (in_valid & in_ready) SHALL write rd at the clock edge 2 cycles after acceptance, when there are no memory waits.
REQ-014 Load data SHALL be captured on the mem_ready cycle and written in WB on the next edge.
REQ-015 ALU codes SHALL be:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
- 0101 SLT (signed), 0110 SLTU.
- 0111 SLL, 1000 SRL, 1001 SRA; shift amount is SrcB[$clog2(DATA_WIDTH)-1:0].
- All other codes produce 0.
- Arithmetic is modulo 2**DATA_WIDTH.
REQ-016 A bubble (in_valid=0, or a stall) SHALL enter EX→MEM as a no-op with reg_write=0 and mem_req=0.
REQ-017 in_ready SHALL depend only on pipeline state and the issue-slot addresses, never on in_valid.

Reset
REQ-018 On rst=1 at a clock edge, all stage valids, alu_result, zero, and all registers SHALL clear to 0.
REQ-019 During and one cycle after reset, mem_req SHALL be 0 and in_ready SHALL be 1.
REQ-020 Reset asserted mid-request SHALL abandon the request without a writeback, regardless of mem_ready.

Structure
REQ-021 Package pipe_pkg SHALL hold the ALU opcode enum alu_op_e, the result-source enum result_src_e, and the stage-register struct types.
REQ-022 The ALU SHALL be the sub-module pipe_alu, purely combinational, parameterised by DATA_WIDTH; the register file and forwarding logic stay inline.

Verification
REQ-023 Issue ADDI x1=x0+5, then ADD x2=x1+x1 back-to-back -> x2=10 via MEM forwarding, no stall.
REQ-024 Issue a store of x1=0x1234 to address 0x40 with mem_ready delayed 3 cycles -> mem_req high exactly 4 cycles, address/data stable, in_ready=0 for those cycles.
REQ-025 Load x3←[0x40] (mem_rdata=0x1234, mem_ready immediate), followed immediately by ADD x4=x3+x3 -> one-cycle in_ready=0, then x4=0x2468.
REQ-026 SUB x5 = 3-3 -> zero=1; SRA of 0x80000000 by 4 -> 0xF8000000; SLT -1<1 -> 1, SLTU -> 0.
REQ-027 Write x0 with 7, then read via test_addr=0 -> 0; a link op with pc_plus4=0x104 and rd=1 -> x1=0x104.
REQ-028 Assert rst during a pending load -> mem_req drops the next cycle, no register changes, in_ready=1.
